mux_sel_arbiter: RTL and testbench
==================================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin select sequencer directly upstream of the 4:1 mux.
//  - Arbitrates four request lines and drives the mux selects c1/c0.
//  - Bounds each grant with a hold counter.
//  - Registers the mux output m as it returns, so consumers see a clean, validated sample.
// PARAMETERS
//  MAX_HOLD  8   max cycles a channel may hold the grant (>=2)
//  HOLD_W    4   hold counter width; must satisfy 2**HOLD_W > MAX_HOLD
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  reset, synchronous, active-low
//  req        in   4  request per channel; req[i] selects mux input xi
//  release_i  in   1  current owner finished; ends grant
//  m          in   1  mux output fed back for capture
//  c0         out  1  mux select LSB (sel = {c1,c0})
//  c1         out  1  mux select MSB
//  grant      out  4  one-hot owner; 0 when idle
//  busy       out  1  grant active
//  m_q        out  1  registered sample of m
//  m_valid    out  1  m_q holds a sample taken under an active grant
//  timeout    out  1  1-cycle pulse: grant ended by MAX_HOLD
// BEHAVIOUR
//  - All outputs registered. Reset (rst_n=0 at a clk edge) forces:
//    c0=c1=0, grant=0, busy=0, m_q=0, m_valid=0, timeout=0, hold_cnt=0,
//    last_ch=3 (ch0 is highest priority after reset), state=IDLE.
//    Reset mid-grant aborts it; no timeout pulse.
//  - FSM: IDLE -> GRANT -> GAP -> IDLE.
//  - IDLE:
//    - If req!=0, pick the first set bit scanning last_ch+1, +2, +3, +4 (mod 4).
//    - Next edge: {c1,c0}=pick, grant=1<<pick, busy=1, hold_cnt=0, go GRANT.
//    - Latency from req seen to grant = 1 cycle. req==0: stay; outputs hold.
//  - GRANT, each cycle:
//    - m_q<=m, m_valid<=1, hold_cnt++.
//    - Exit to GAP when any of: release_i=1; req[owner]=0; hold_cnt==MAX_HOLD-1.
//    - timeout<=1 only when the hold limit is the sole exit cause.
//      release_i or a dropped req in the same cycle suppresses it.
//  - GAP (exactly 1 cycle):
//    - grant=0, busy=0, m_valid=0, timeout returns to 0.
//    - c1/c0 hold the last value so the mux output stays stable.
//    - last_ch<=owner; go IDLE.
//  - Fairness: after a grant the owner is lowest priority. A requester is never skipped
//    more than 3 grants. Arbitration uses req sampled in IDLE only.
//  - The GAP cycle guarantees grant is low for at least 1 cycle between owners.
//    Back-to-back grants to one channel are therefore impossible.
//  - hold_cnt saturates by construction (exit at MAX_HOLD-1); no wrap.
//  - m_valid never rises outside GRANT.
//  - m_q holds its last value when m_valid=0.
// STRUCTURE
//  - Shared header mux_sel_defs.vh holds: state encodings IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
//    N_CH=4; SEL_W=2.
//  - Sub-module rr_pick4 (combinational): inputs req[3:0], last_ch[1:0];
//    outputs pick[1:0], any.
//  - Top holds the FSM, hold counter, last_ch and capture registers.
// TESTING
//  1. Reset: rst_n=0 for 2 clks with req=4'hF -> all outputs 0. rst_n=1 -> grant=4'b0001,
//     {c1,c0}=0, busy=1 one clk later.
//  2. Round-robin: req=4'hF held, release_i pulsed every 3rd GRANT cycle
//     -> grant order 0001,0010,0100,1000,0001. 1 idle-grant cycle between grants.
//  3. Timeout: req=4'b0100 held, release_i=0 -> grant held 8 clks, timeout=1 for 1 clk.
//     Next grant back to ch2 after GAP+IDLE.
//  4. Release/timeout collision: release_i=1 on the 8th GRANT cycle -> timeout stays 0.
//  5. Capture: grant ch3, drive m=1,0,1 -> m_q follows 1 clk later, m_valid=1 only
//     during GRANT.
//  6. Reset mid-grant at hold_cnt=3 -> next edge grant=0, busy=0, timeout=0, last_ch=3.

Source files
------------

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter: FSM states, channel
// count, select width and a small one-hot helper.
package mux_sel_arbiter_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Channel index to one-hot grant vector.
    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] ch);
        logic [N_CH-1:0] r;
        r     = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational round-robin picker for four requesters. The channel
// immediately after last_ch has the highest priority and last_ch itself
// has the lowest.
module rr_pick4
    import mux_sel_arbiter_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_ch,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = last_ch + SEL_W'(N_CH - k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select sequencer placed in front of a 4:1 mux. Grants one
// requester at a time, drives the mux selects, bounds each grant with a
// hold counter and registers the returning mux output.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    input  logic            release_i,
    input  logic            m,
    output logic            c0,
    output logic            c1,
    output logic [N_CH-1:0] grant,
    output logic            busy,
    output logic            m_q,
    output logic            m_valid,
    output logic            timeout
);

    state_t           state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [SEL_W-1:0] last_ch;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] pick;
    logic             any_req;
    logic             rel_cause;
    logic             hold_lim;

    rr_pick4 u_pick (
        .req     (req),
        .last_ch (last_ch),
        .pick    (pick),
        .any     (any_req)
    );

    // The registered select is also the current owner index.
    assign c0 = sel_q[0];
    assign c1 = sel_q[1];

    // Exit causes while granted: owner-driven end versus hold limit.
    always_comb begin
        rel_cause = release_i | ~req[sel_q];
        hold_lim  = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    end

    // Arbitration FSM with hold counter, fairness pointer and m capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_ch  <= SEL_W'(N_CH - 1);
            sel_q    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            m_q      <= 1'b0;
            m_valid  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_q    <= pick;
                        grant    <= onehot(pick);
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    m_q      <= m;
                    m_valid  <= 1'b1;
                    hold_cnt <= hold_cnt + 1'b1;
                    if (rel_cause || hold_lim) begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= hold_lim & ~rel_cause;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    // Selects stay put so the mux output does not glitch.
                    timeout <= 1'b0;
                    m_valid <= 1'b0;
                    last_ch <= sel_q;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: a reference model pushes the
// expected outputs for every driven cycle, each scenario pops and compares
// them, and adds scenario-level checks against fixed expected values.
module tb_mux_sel_arbiter;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       release_i;
    logic       m;
    logic       c0, c1;
    logic [3:0] grant;
    logic       busy, m_q, m_valid, timeout;
    logic [9:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    // expected {grant, c1, c0, busy, m_q, m_valid, timeout}
    logic [9:0] exp_q[$];

    // reference model state
    int         mdl_phase;   // 0 idle, 1 granted, 2 gap
    int         mdl_hold;
    logic [1:0] mdl_owner, mdl_last;
    logic [3:0] e_grant;
    logic [1:0] e_sel;
    logic       e_busy, e_mq, e_mv, e_to;

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .release_i (release_i),
        .m         (m),
        .c0        (c0),
        .c1        (c1),
        .grant     (grant),
        .busy      (busy),
        .m_q       (m_q),
        .m_valid   (m_valid),
        .timeout   (timeout)
    );

    assign obs = {grant, c1, c0, busy, m_q, m_valid, timeout};

    always #5 clk = ~clk;

    task automatic model_step(input logic r_n, input logic [3:0] r,
                              input logic rel, input logic mm);
        bit found;
        bit cause, lim;
        int ch;
        if (!r_n) begin
            mdl_phase = 0; mdl_hold = 0; mdl_last = 2'd3; mdl_owner = 2'd0;
            e_grant = 4'b0; e_sel = 2'd0; e_busy = 0; e_mq = 0; e_mv = 0; e_to = 0;
        end else if (mdl_phase == 0) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                ch = (int'(mdl_last) + k) % 4;
                if (!found && r[ch]) begin
                    found = 1;
                    mdl_owner = 2'(ch);
                end
            end
            if (found) begin
                e_sel = mdl_owner; e_grant = 4'b0001 << mdl_owner; e_busy = 1;
                mdl_hold = 0; mdl_phase = 1;
            end
        end else if (mdl_phase == 1) begin
            e_mq = mm; e_mv = 1;
            cause = rel || !r[mdl_owner];
            lim = (mdl_hold == MAX_HOLD - 1);
            mdl_hold++;
            if (cause || lim) begin
                e_grant = 4'b0; e_busy = 0; e_to = lim && !cause; mdl_phase = 2;
            end
        end else begin
            e_to = 0; e_mv = 0; mdl_last = mdl_owner; mdl_phase = 0;
        end
    endtask

    task automatic tick(input logic r_n, input logic [3:0] r,
                        input logic rel, input logic mm);
        rst_n = r_n; req = r; release_i = rel; m = mm;
        model_step(r_n, r, rel, mm);
        exp_q.push_back({e_grant, e_sel, e_busy, e_mq, e_mv, e_to});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            tick(0, 4'hF, 0, 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL reset_model%0d: got %b want %b", i, obs, e); end
            n_checks++;
            if (obs !== 10'b0) begin n_errors++; $display("FAIL reset_zero%0d: got %b want 0", i, obs); end
        end
        tick(1, 4'hF, 0, 0);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL reset_first_model: got %b want %b", obs, e); end
        n_checks++;
        if ({grant, c1, c0, busy} !== 7'b0001_00_1) begin
            n_errors++; $display("FAIL reset_first_grant: got %b want 0001001", {grant, c1, c0, busy});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, (i == 0) ? 4'hF : 4'h0, (i == 0), 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL reset_tail%0d: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_round_robin();
        logic [9:0] e;
        logic [3:0] order[$];
        int highs[$];
        int lows[$];
        logic [3:0] prev_g;
        logic [3:0] exp_order[5];
        int hi_run, lo_run;
        bit rel;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tick(0, 4'hF, 0, 0);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL rr_reset: got %b want %b", obs, e); end
        prev_g = 4'b0; hi_run = 0; lo_run = 0;
        for (int i = 0; i < 25; i++) begin
            rel = (mdl_phase == 1 && mdl_hold == 2);
            tick(1, 4'hF, rel, 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL rr_cycle%0d: got %b want %b", i, obs, e); end
            if (grant != 4'b0) begin
                if (prev_g == 4'b0) begin
                    order.push_back(grant);
                    if (order.size() > 1) lows.push_back(lo_run);
                    hi_run = 0;
                end
                hi_run++;
            end else begin
                if (prev_g != 4'b0) begin highs.push_back(hi_run); lo_run = 0; end
                lo_run++;
            end
            prev_g = grant;
        end
        n_checks++;
        if (order.size() != 5 || highs.size() != 5 || lows.size() != 4) begin
            n_errors++;
            $display("FAIL rr_counts: got grants=%0d highs=%0d gaps=%0d want 5 5 4",
                     order.size(), highs.size(), lows.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (order[k] !== exp_order[k]) begin
                    n_errors++; $display("FAIL rr_order%0d: got %b want %b", k, order[k], exp_order[k]);
                end
                n_checks++;
                if (highs[k] != 3) begin
                    n_errors++; $display("FAIL rr_hold%0d: got %0d want 3", k, highs[k]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (lows[k] != 2) begin
                    n_errors++; $display("FAIL rr_gap%0d: got %0d want 2", k, lows[k]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        int hi_cnt, to_cnt, to_idx;
        bit fell;
        hi_cnt = 0; to_cnt = 0; to_idx = -1; fell = 0;
        for (int i = 0; i < 11; i++) begin
            tick(1, 4'b0100, 0, 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL to_cycle%0d: got %b want %b", i, obs, e); end
            if (grant == 4'b0100 && !fell) hi_cnt++;
            if (grant == 4'b0 && hi_cnt > 0) fell = 1;
            if (timeout === 1'b1) begin to_cnt++; to_idx = i; end
        end
        n_checks++;
        if (hi_cnt != MAX_HOLD) begin n_errors++; $display("FAIL to_hold_len: got %0d want %0d", hi_cnt, MAX_HOLD); end
        n_checks++;
        if (to_cnt != 1 || to_idx != 8) begin
            n_errors++; $display("FAIL to_pulse: got count=%0d at=%0d want count=1 at=8", to_cnt, to_idx);
        end
        n_checks++;
        if (grant !== 4'b0100) begin n_errors++; $display("FAIL to_regrant: got %b want 0100", grant); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 4'b0000, 0, 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL to_drain%0d: got %b want %b", i, obs, e); end
            n_checks++;
            if (timeout !== 1'b0) begin n_errors++; $display("FAIL to_drop_no_pulse%0d: got %b want 0", i, timeout); end
        end
    endtask

    task automatic test_collision();
        logic [9:0] e;
        int hi_cnt, to_cnt;
        bit rel;
        logic [3:0] r;
        hi_cnt = 0; to_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            rel = (mdl_phase == 1 && mdl_hold == MAX_HOLD - 1);
            r = (mdl_phase == 2 || i > 8) ? 4'b0000 : 4'b0100;
            tick(1, r, rel, 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL col_cycle%0d: got %b want %b", i, obs, e); end
            if (grant != 4'b0) hi_cnt++;
            if (timeout !== 1'b0) to_cnt++;
        end
        n_checks++;
        if (hi_cnt != MAX_HOLD) begin n_errors++; $display("FAIL col_hold_len: got %0d want %0d", hi_cnt, MAX_HOLD); end
        n_checks++;
        if (to_cnt != 0) begin n_errors++; $display("FAIL col_timeout: got %0d pulses want 0", to_cnt); end
    endtask

    task automatic test_capture();
        logic [9:0] e;
        logic       m_seq[7]   = '{0, 1, 0, 1, 0, 1, 1};
        logic       rel_seq[7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [3:0] req_seq[7] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
        logic       exp_mq[7]  = '{0, 1, 0, 1, 0, 0, 0};
        logic       exp_mv[7]  = '{0, 1, 1, 1, 1, 0, 0};
        logic [1:0] exp_sel[7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 7; i++) begin
            tick(1, req_seq[i], rel_seq[i], m_seq[i]);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL cap_cycle%0d: got %b want %b", i, obs, e); end
            n_checks++;
            if ({m_q, m_valid, c1, c0} !== {exp_mq[i], exp_mv[i], exp_sel[i]}) begin
                n_errors++;
                $display("FAIL cap_sample%0d: got mq/mv/sel=%b want %b", i,
                         {m_q, m_valid, c1, c0}, {exp_mq[i], exp_mv[i], exp_sel[i]});
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [9:0] e;
        logic [3:0] r_seq[8]   = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
        logic       rel_seq[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            tick(1, r_seq[i], rel_seq[i], 0);
            e = exp_q.pop_front(); n_checks++;
            if (obs !== e) begin n_errors++; $display("FAIL mid_setup%0d: got %b want %b", i, obs, e); end
        end
        n_checks++;
        if (grant !== 4'b0010 || dut.hold_cnt !== 4'd3) begin
            n_errors++; $display("FAIL mid_pre: got grant=%b hold=%0d want 0010 3", grant, dut.hold_cnt);
        end
        tick(0, 4'hF, 1, 0);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL mid_reset_model: got %b want %b", obs, e); end
        n_checks++;
        if ({grant, busy, timeout} !== 6'b0) begin
            n_errors++; $display("FAIL mid_reset_outs: got %b want 000000", {grant, busy, timeout});
        end
        tick(1, 4'hF, 0, 0);
        e = exp_q.pop_front(); n_checks++;
        if (obs !== e) begin n_errors++; $display("FAIL mid_after_model: got %b want %b", obs, e); end
        n_checks++;
        if (grant !== 4'b0001) begin n_errors++; $display("FAIL mid_after_grant: got %b want 0001", grant); end
    endtask

    initial begin
        clk = 0; rst_n = 0; req = '0; release_i = 0; m = 0;
        test_reset();
        test_round_robin();
        test_timeout();
        test_collision();
        test_capture();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
